// File: rtl/cpu_hazard_ctrl_pkg.sv
// Shared CPU constants for the hazard scoreboard: register file shape,
// operand encoding and default forwardability latencies.
package cpu_pkg;
    localparam int NREG      = 8;  // architectural registers
    localparam int REG_W     = 3;  // register address width
    localparam int OPND_W    = 4;  // source operand width
    localparam int NOREG_BIT = 3;  // operand bit meaning "no register"
    localparam int CNT_W     = 2;  // per-register countdown width
    localparam int ALU_LAT   = 1;  // countdown for a non-load writer
    localparam int LD_LAT    = 2;  // countdown for a load writer

    typedef logic [REG_W-1:0]  reg_addr_t;
    typedef logic [OPND_W-1:0] opnd_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Saturating decrement toward zero.
    function automatic cnt_t cnt_dec(input cnt_t x);
        return (x != '0) ? cnt_t'(x - 1'b1) : '0;
    endfunction
endpackage

// File: rtl/cpu_hazard_ctrl_if.sv
// Decode-stage issue bus into the hazard scoreboard and its stall/status
// returns. The pipeline drives as master, the scoreboard is the slave.
interface cpu_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    import cpu_pkg::*;

    logic              issue_valid;
    opnd_t             issue_rx;
    opnd_t             issue_ry;
    logic              issue_wr_en;
    reg_addr_t         issue_wr_reg;
    logic              issue_is_load;
    logic              flush;
    logic              o_stall;
    logic              o_busy;
    logic [PERF_W-1:0] o_stall_cnt;

    modport master (
        output issue_valid, issue_rx, issue_ry, issue_wr_en, issue_wr_reg,
               issue_is_load, flush,
        input  o_stall, o_busy, o_stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rx, issue_ry, issue_wr_en, issue_wr_reg,
               issue_is_load, flush,
        output o_stall, o_busy, o_stall_cnt
    );
endinterface

// File: rtl/cpu_hazard_cnt.sv
// Single-register forwardability countdown. A new writer never shortens
// an in-flight countdown (WAW: younger ALU op behind an older load).
module cpu_hazard_cnt
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load_en,
    input  cnt_t load_val,
    output cnt_t cnt
);
    cnt_t dec_val;

    assign dec_val = cnt_dec(cnt);

    // Countdown register: reset, then flush, then load-with-max, else decrement.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load_en)
            cnt <= (load_val > dec_val) ? load_val : dec_val;
        else
            cnt <= dec_val;
    end
endmodule

// File: rtl/cpu_hazard_ctrl.sv
// Register-hazard scoreboard at the decode/execute boundary. Stalls decode
// while a source register's result is still two or more cycles from being
// forwardable, and counts stall cycles (saturating).
module cpu_hazard_ctrl
    import cpu_pkg::REG_W, cpu_pkg::CNT_W, cpu_pkg::NOREG_BIT, cpu_pkg::cnt_t;
#(
    parameter int NREG    = cpu_pkg::NREG,
    parameter int ALU_LAT = cpu_pkg::ALU_LAT,
    parameter int LD_LAT  = cpu_pkg::LD_LAT,
    parameter int PERF_W  = 16
) (
    input logic              clk,
    input logic              reset,
    cpu_hazard_ctrl_if.slave bus
);
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [PERF_W-1:0]          stall_cnt;
    logic                       hot_x;
    logic                       hot_y;
    logic                       stall;
    logic                       accept;
    cnt_t                       lat;

    // A source is hot when it names register r and r is not yet forwardable.
    always_comb begin
        hot_x = 1'b0;
        hot_y = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (!bus.issue_rx[NOREG_BIT] && bus.issue_rx[REG_W-1:0] == REG_W'(r)
                && cnt[r] >= cnt_t'(2))
                hot_x = 1'b1;
            if (!bus.issue_ry[NOREG_BIT] && bus.issue_ry[REG_W-1:0] == REG_W'(r)
                && cnt[r] >= cnt_t'(2))
                hot_y = 1'b1;
        end
    end

    assign stall  = bus.issue_valid && !bus.flush && (hot_x || hot_y);
    assign accept = bus.issue_valid && !stall && !bus.flush;
    assign lat    = bus.issue_is_load ? cnt_t'(LD_LAT) : cnt_t'(ALU_LAT);

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        cpu_hazard_cnt u_cnt (
            .clk      (clk),
            .reset    (reset),
            .clr      (bus.flush),
            .load_en  (accept && bus.issue_wr_en && bus.issue_wr_reg == REG_W'(g)),
            .load_val (lat),
            .cnt      (cnt[g])
        );
    end

    // Stall-cycle perf counter: saturates at all-ones, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign bus.o_stall     = stall;
    assign bus.o_busy      = |cnt;
    assign bus.o_stall_cnt = stall_cnt;
endmodule

// File: tb/tb_cpu_hazard_ctrl.sv
// Bench for cpu_hazard_ctrl: a table of per-cycle vectors plus a
// load-use loop that drives the stall counter into saturation.
module tb_cpu_hazard_ctrl;
    localparam int PW = 4;

    typedef struct {
        string      name;
        logic       rst, vld;
        logic [3:0] rx, ry;
        logic       wen;
        logic [2:0] wr;
        logic       ld, fl, chk;
        logic       es, eb;
        logic [3:0] ec;
    } vec_t;

    typedef struct {
        string      name;
        logic       es, eb;
        logic [3:0] ec;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t tbl[$];
    exp_t exp_q[$];

    cpu_hazard_ctrl_if #(.PERF_W(PW)) bus ();

    cpu_hazard_ctrl #(.PERF_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic rst, logic vld, logic [3:0] rx,
                                logic [3:0] ry, logic wen, logic [2:0] wr, logic ld,
                                logic fl, logic chk, logic es, logic eb, logic [3:0] ec);
        vec_t v;
        v.name = n; v.rst = rst; v.vld = vld; v.rx = rx; v.ry = ry; v.wen = wen;
        v.wr = wr; v.ld = ld; v.fl = fl; v.chk = chk; v.es = es; v.eb = eb; v.ec = ec;
        return v;
    endfunction

    // Drive one cycle, queue its expectation, compare mid-cycle, advance.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        reset             = v.rst;
        bus.issue_valid   = v.vld;
        bus.issue_rx      = v.rx;
        bus.issue_ry      = v.ry;
        bus.issue_wr_en   = v.wen;
        bus.issue_wr_reg  = v.wr;
        bus.issue_is_load = v.ld;
        bus.flush         = v.fl;
        if (v.chk) begin
            e.name = v.name; e.es = v.es; e.eb = v.eb; e.ec = v.ec;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            n_vec++;
            if (bus.o_stall !== got.es || bus.o_busy !== got.eb || bus.o_stall_cnt !== got.ec) begin
                n_miss++;
                $display("FAIL %s: stall/busy/cnt got %b/%b/%0d want %b/%b/%0d", got.name,
                         bus.o_stall, bus.o_busy, bus.o_stall_cnt, got.es, got.eb, got.ec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sc;
        //                 name    rst vld rx     ry     wen wr ld fl chk st by sc
        tbl.push_back(mk("rst0",   1, 1, 4'h3, 4'h5, 1, 3, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk("rst1",   1, 1, 4'h3, 4'h5, 1, 3, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk("alu_w3", 0, 1, 4'h8, 4'h8, 1, 3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("alu_use",0, 1, 4'h3, 4'h8, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(mk("alu_idl",0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("ld_w5",  0, 1, 4'h8, 4'h8, 1, 5, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk("ld_use", 0, 1, 4'h8, 4'h5, 1, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("ld_acc", 0, 1, 4'h8, 4'h5, 1, 1, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("ld_idl", 0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("ld_w5b", 0, 1, 4'h8, 4'h8, 1, 5, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("noreg",  0, 1, 4'h8, 4'hD, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("nr_idl", 0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("waw_ld", 0, 1, 4'h8, 4'h8, 1, 2, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("waw_alu",0, 1, 4'h8, 4'h8, 1, 2, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("waw_use",0, 1, 4'h2, 4'h8, 0, 0, 0, 0, 1, 0, 1, 1));
        tbl.push_back(mk("waw_idl",0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("fl_ld6", 0, 1, 4'h8, 4'h8, 1, 6, 1, 1, 1, 0, 0, 1));
        tbl.push_back(mk("fl_use6",0, 1, 4'h6, 4'h8, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("fl_ld4", 0, 1, 4'h8, 4'h8, 1, 4, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("fl_mid", 0, 1, 4'h4, 4'h8, 0, 0, 0, 1, 1, 0, 1, 1));
        tbl.push_back(mk("fl_aft", 0, 1, 4'h4, 4'h8, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk("rs_ld7", 0, 1, 4'h8, 4'h8, 1, 7, 1, 0, 1, 0, 0, 1));
        tbl.push_back(mk("rs_mid", 1, 1, 4'h7, 4'h8, 0, 0, 0, 0, 1, 1, 1, 1));
        tbl.push_back(mk("rs_aft", 0, 1, 4'h7, 4'h8, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk("r0_ld",  0, 1, 4'h8, 4'h8, 1, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk("r0_use", 0, 1, 4'h0, 4'h8, 0, 0, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk("r0_acc", 0, 1, 4'h0, 4'h8, 0, 0, 0, 0, 1, 0, 1, 1));

        @(posedge clk);
        #1;
        foreach (tbl[i]) step(tbl[i]);

        // Saturation: load-use pairs, one stall cycle each, from a clean reset.
        step(mk("sat_rst", 1, 0, 4'h8, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0));
        sc = 4'd0;
        for (int k = 0; k < 20; k++) begin
            step(mk($sformatf("sat_ld%0d", k),  0, 1, 4'h8, 4'h8, 1, 5, 1, 0, 1, 0, 0, sc));
            step(mk($sformatf("sat_stl%0d", k), 0, 1, 4'h8, 4'h5, 0, 0, 0, 0, 1, 1, 1, sc));
            if (sc != 4'd15) sc = sc + 4'd1;
            step(mk($sformatf("sat_acc%0d", k), 0, 1, 4'h8, 4'h5, 0, 0, 0, 0, 1, 0, 1, sc));
        end
        step(mk("sat_hold", 0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 0, 4'd15));
        step(mk("sat_rs",   1, 1, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 0, 4'd15));
        step(mk("sat_clr",  0, 0, 4'h8, 4'h8, 0, 0, 0, 0, 1, 0, 0, 4'd0));

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
